// File: rtl/sysbus_pkg.sv
// Shared types and constants for the sysbus memory responder.
// Request tag layout, direction/type codes, line geometry and the FSM state encoding.
package sysbus_pkg;

  localparam logic       DIR_READ    = 1'b1;
  localparam logic       DIR_WRITE   = 1'b0;
  localparam logic [3:0] TYPE_MEMORY = 4'd1;
  localparam int         LINE_BEATS  = 8;
  localparam int         BEAT_BITS   = 3;

  typedef struct packed {
    logic       dir;
    logic [3:0] kind;
    logic [7:0] id;
  } reqtag_t;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    WAIT,
    RESP,
    WDATA
  } state_t;

endpackage

// File: rtl/sysbus_line_ram.sv
// Line storage: DEPTH_LINES lines of LINE_BEATS 64-bit words.
// One write port, one read port with a registered read; contents are never reset.
module sysbus_line_ram
  import sysbus_pkg::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_LINES * LINE_BEATS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_data
);

  logic [63:0] mem [DEPTH_LINES*LINE_BEATS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: acks a line request, then streams or absorbs 8 beats.
// Define SYSBUS_RESP_WRITE_EN to let WRITE bursts update storage; otherwise storage is read-only.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  localparam int LINE_W = $clog2(DEPTH_LINES);
  localparam int ADDR_W = LINE_W + BEAT_BITS;
  localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 2);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

  state_t               state_q, state_d;
  logic [LINE_W-1:0]    line_q, line_d;
  reqtag_t              tag_q, tag_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 reqack_q, reqack_d;
  logic                 wdata_take;
  logic                 we;
  logic [BEAT_BITS-1:0] rd_beat;
  logic [ADDR_W-1:0]    rd_addr;
  logic [ADDR_W-1:0]    wr_addr;
  logic [63:0]          rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      line_q   <= '0;
      tag_q    <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      reqack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      reqack_q <= reqack_d;
    end
  end

  // The initiator still holds reqcyc during the cycle its ack is shown, so no
  // request or data beat is taken while reqack is high.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    tag_d      = tag_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    reqack_d   = 1'b0;
    wdata_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqcyc && !reqack_q) begin
          line_d   = req[6 +: LINE_W];
          tag_d    = reqtag;
          reqack_d = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        beat_d = '0;
        cnt_d  = '0;
        if (tag_q.dir == DIR_WRITE) begin
          state_d = WDATA;
        end else if (LATENCY == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (respack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      WDATA: begin
        if (reqcyc && !reqack_q) begin
          wdata_take = 1'b1;
          reqack_d   = 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SYSBUS_RESP_WRITE_EN
  assign we = wdata_take && (tag_q.kind == TYPE_MEMORY);
`else
  logic unused_wdata_take;
  assign unused_wdata_take = wdata_take;
  assign we = 1'b0;
`endif

  // Read one beat ahead on acceptance so the registered RAM output tracks the presented beat.
  assign rd_beat = (state_q == RESP && respack) ? beat_q + 1'b1 : beat_q;
  assign rd_addr = {line_q, rd_beat};
  assign wr_addr = {line_q, beat_q};

  sysbus_line_ram #(
    .DEPTH_LINES(DEPTH_LINES),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(req),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign reqack  = reqack_q;
  assign respcyc = (state_q == RESP);
  assign resp    = (respcyc && tag_q.kind == TYPE_MEMORY) ? rd_data : '0;
  assign resptag = tag_q;

endmodule
